coin_credit_accumulator: RTL and testbench

//  Upstream stage of the juice vending FSM. It debounces the raw coin inputs ($1/$2/$5) and

---
 rtl/juice_pkg.sv | 30 +++
 rtl/coin_credit_accumulator_filter.sv | 56 +++++
 rtl/coin_credit_accumulator.sv | 256 +++++++++++++++++++++++++
 tb/tb_coin_credit_accumulator.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/juice_pkg.sv
// -----------------------------------------------------------------------------
// juice_pkg
// Shared definitions for the juice vending front end: the credit FSM state
// encoding, coin denominations, vend_item encodings and default product
// prices (the same defaults are used by the downstream juice FSM).
// -----------------------------------------------------------------------------
package juice_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  // Coin denominations in dollars
  localparam int COIN_VAL_1 = 1;
  localparam int COIN_VAL_2 = 2;
  localparam int COIN_VAL_5 = 5;

  // vend_item encodings
  localparam logic [1:0] ITEM_NONE = 2'd0;
  localparam logic [1:0] ITEM_1    = 2'd1;
  localparam logic [1:0] ITEM_2    = 2'd2;

  // Default prices, shared with the juice FSM
  localparam int PRICE_1_DEF = 3;
  localparam int PRICE_2_DEF = 5;

endpackage

// File: rtl/coin_credit_accumulator_filter.sv
// -----------------------------------------------------------------------------
// coin_pulse_filter
// Conditions one raw coin-slot level: a 2-flop synchroniser followed by a
// debounce counter. After DEBOUNCE_CYC consecutive high samples of the
// synchronised level, accept is high for exactly one cycle. The filter
// re-arms only after the synchronised level has returned low, so a coin
// held in the slot is credited once. Shorter highs never reach the count.
//
// Ports
//   clk       in  1  system clock, rising edge
//   rst       in  1  asynchronous reset, active-high
//   coin_raw  in  1  raw, unsynchronised coin level
//   accept    out 1  one-cycle accept pulse (combinational from registers)
// -----------------------------------------------------------------------------
module coin_pulse_filter #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic coin_raw,
  output logic accept
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
    $error("coin_pulse_filter: DEBOUNCE_CYC must be at least 1");
  end

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  // cnt counts high samples of sync_2 and saturates at DEBOUNCE_CYC, which
  // doubles as the "already fired, wait for low" state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_1 <= coin_raw;
      sync_2 <= sync_1;
      if (!sync_2) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(DEBOUNCE_CYC)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // The DEBOUNCE_CYC-th high sample is the one seen while cnt is one short
  // of saturation; firing here keeps raw-edge-to-credit at 2 + DEBOUNCE_CYC.
  assign accept = sync_2 && (cnt == CNT_W'(DEBOUNCE_CYC - 1));

endmodule

// File: rtl/coin_credit_accumulator.sv
// -----------------------------------------------------------------------------
// coin_credit_accumulator
// Front end of the juice vending machine. Filters the three raw coin inputs,
// accumulates credit, accepts a product selection once credit covers its
// price, issues a vend request and then returns any change.
//
// Optional feature: define COIN_TIMEOUT_EN to refund the full credit after
// TIMEOUT_CYC cycles of inactivity in ACCUM.
//
// Handshakes (vend_*, change_*): valid/data are registered and held stable
// from assertion until the cycle in which ready is sampled high; a transfer
// happens on that rising edge and valid drops in the following cycle. valid
// never drops without ready, and ready with valid low is ignored.
//
// Ports
//   clk           in   1         system clock, rising edge
//   rst           in   1         asynchronous reset, active-high
//   coin_1/2/5    in   1 each    raw coin-slot levels
//   sel_1, sel_2  in   1 each    product buttons, one-cycle pulses
//   cancel        in   1         refund request, one-cycle pulse
//   vend_valid    out  1         vend request valid
//   vend_item     out  2         requested item (ITEM_1/ITEM_2), 0 when idle
//   vend_ready    in   1         juice FSM accepts the request
//   change_valid  out  1         change ready to dispense
//   change_amt    out  CREDIT_W  change amount in dollars
//   change_ready  in   1         change dispenser accepts
//   credit        out  CREDIT_W  current credit for display
//   coin_reject   out  1         one-cycle pulse, coin routed to reject chute
//   fsm_state     out  state_t   current FSM state, for debug/observation
// -----------------------------------------------------------------------------
module coin_credit_accumulator
  import juice_pkg::*;
#(
  parameter int CREDIT_W     = 5,
  parameter int MAX_CREDIT   = 20,
  parameter int PRICE_1      = PRICE_1_DEF,
  parameter int PRICE_2      = PRICE_2_DEF,
  parameter int DEBOUNCE_CYC = 4,
  parameter int TIMEOUT_CYC  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_1,
  input  logic                coin_2,
  input  logic                coin_5,
  input  logic                sel_1,
  input  logic                sel_2,
  input  logic                cancel,
  output logic                vend_valid,
  output logic [1:0]          vend_item,
  input  logic                vend_ready,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output state_t              fsm_state
);

  // Largest transient sum is MAX_CREDIT plus the biggest coin.
  if (MAX_CREDIT + COIN_VAL_5 > (1 << CREDIT_W) - 1) begin : g_bad_width
    $error("coin_credit_accumulator: MAX_CREDIT+5 does not fit in CREDIT_W bits");
  end
  if (TIMEOUT_CYC < 1 || PRICE_1 < 1 || PRICE_2 < 1) begin : g_bad_param
    $error("coin_credit_accumulator: TIMEOUT_CYC and prices must be at least 1");
  end

  localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] P1_C  = CREDIT_W'(PRICE_1);
  localparam logic [CREDIT_W-1:0] P2_C  = CREDIT_W'(PRICE_2);

  state_t state;
  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // Coin filters
  // ---------------------------------------------------------------------------
  logic acc_1;
  logic acc_2;
  logic acc_5;

  coin_pulse_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_filt_1 (
    .clk      (clk),
    .rst      (rst),
    .coin_raw (coin_1),
    .accept   (acc_1)
  );

  coin_pulse_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_filt_2 (
    .clk      (clk),
    .rst      (rst),
    .coin_raw (coin_2),
    .accept   (acc_2)
  );

  coin_pulse_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_filt_5 (
    .clk      (clk),
    .rst      (rst),
    .coin_raw (coin_5),
    .accept   (acc_5)
  );

  // ---------------------------------------------------------------------------
  // Coin evaluation
  // ---------------------------------------------------------------------------
  logic [1:0]          n_acc;      // number of coins accepted this cycle
  logic                any_coin;
  logic                coin_ok;    // exactly one coin and it fits under MAX
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] credit_sum;

  always_comb begin
    n_acc    = 2'(acc_1) + 2'(acc_2) + 2'(acc_5);
    any_coin = (n_acc != 2'd0);
    coin_val = '0;
    if (acc_1) coin_val = CREDIT_W'(COIN_VAL_1);
    if (acc_2) coin_val = CREDIT_W'(COIN_VAL_2);
    if (acc_5) coin_val = CREDIT_W'(COIN_VAL_5);
    credit_sum = credit + coin_val;
    coin_ok    = (n_acc == 2'd1) && (credit_sum <= MAX_C);
  end

  // ---------------------------------------------------------------------------
  // Selection and vend arithmetic
  // ---------------------------------------------------------------------------
  logic                sel1_ok;
  logic                sel2_ok;
  logic [CREDIT_W-1:0] vend_price;
  logic [CREDIT_W-1:0] remainder;

  always_comb begin
    sel1_ok    = sel_1 && (credit >= P1_C);
    sel2_ok    = sel_2 && (credit >= P2_C);
    vend_price = (vend_item == ITEM_1) ? P1_C : P2_C;
    // credit >= vend_price is guaranteed while in VEND
    remainder  = credit - vend_price;
  end

  // ---------------------------------------------------------------------------
  // Inactivity timeout
  // ---------------------------------------------------------------------------
  logic timeout_hit;

`ifdef COIN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt;

  // Cleared by any coin event that can enter or stay in ACCUM, and by any
  // selection attempt in ACCUM; otherwise counts only while in ACCUM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (any_coin && (state == IDLE || state == ACCUM)) begin
      to_cnt <= '0;
    end else if (state == ACCUM) begin
      if (sel_1 || sel_2) begin
        to_cnt <= '0;
      end else if (!timeout_hit) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  assign timeout_hit = (state == ACCUM) && (to_cnt == TO_W'(TIMEOUT_CYC));
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Credit FSM, all outputs registered
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      credit       <= '0;
      vend_valid   <= 1'b0;
      vend_item    <= ITEM_NONE;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      case (state)
        IDLE: begin
          if (any_coin) begin
            if (coin_ok) begin
              credit <= credit_sum;
              state  <= ACCUM;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end

        ACCUM: begin
          // A coin landing in the same cycle as a state change is refused so
          // it cannot alter a credit that is already being refunded or spent.
          if (cancel || timeout_hit) begin
            state        <= CHANGE;
            change_valid <= 1'b1;
            change_amt   <= credit;
            coin_reject  <= any_coin;
          end else if (sel1_ok) begin
            state       <= VEND;
            vend_valid  <= 1'b1;
            vend_item   <= ITEM_1;
            coin_reject <= any_coin;
          end else if (sel2_ok) begin
            state       <= VEND;
            vend_valid  <= 1'b1;
            vend_item   <= ITEM_2;
            coin_reject <= any_coin;
          end else if (any_coin) begin
            if (coin_ok) begin
              credit <= credit_sum;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end

        VEND: begin
          coin_reject <= any_coin;
          if (vend_ready) begin
            vend_valid <= 1'b0;
            vend_item  <= ITEM_NONE;
            credit     <= remainder;
            if (remainder != '0) begin
              state        <= CHANGE;
              change_valid <= 1'b1;
              change_amt   <= remainder;
            end else begin
              state <= IDLE;
            end
          end
        end

        CHANGE: begin
          coin_reject <= any_coin;
          if (change_ready) begin
            change_valid <= 1'b0;
            change_amt   <= '0;
            credit       <= '0;
            state        <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// -----------------------------------------------------------------------------
// tb_coin_credit_accumulator
// Directed scenarios followed by a randomized transaction sequence. A
// transaction-level credit model (a single integer balance plus the price
// and ceiling rules) supplies every expected value.
// -----------------------------------------------------------------------------
module tb_coin_credit_accumulator;
  import juice_pkg::*;

  localparam int CW    = 5;
  localparam int MAXC  = 20;
  localparam int PR1   = 3;
  localparam int PR2   = 5;
  localparam int DEB   = 4;
  localparam int TO    = 1000;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          coin_1 = 1'b0, coin_2 = 1'b0, coin_5 = 1'b0;
  logic          sel_1 = 1'b0, sel_2 = 1'b0, cancel = 1'b0;
  logic          vend_ready = 1'b0, change_ready = 1'b0;
  logic          vend_valid, change_valid, coin_reject;
  logic [1:0]    vend_item;
  logic [CW-1:0] change_amt, credit;
  state_t        fsm_state;

  always #5 clk = ~clk;

  coin_credit_accumulator #(
    .CREDIT_W(CW), .MAX_CREDIT(MAXC), .PRICE_1(PR1), .PRICE_2(PR2),
    .DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .coin_1(coin_1), .coin_2(coin_2), .coin_5(coin_5),
    .sel_1(sel_1), .sel_2(sel_2), .cancel(cancel),
    .vend_valid(vend_valid), .vend_item(vend_item), .vend_ready(vend_ready),
    .change_valid(change_valid), .change_amt(change_amt), .change_ready(change_ready),
    .credit(credit), .coin_reject(coin_reject), .fsm_state(fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int model_credit = 0;   // expected balance in dollars

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_coin(input int v, input logic lvl);
    case (v)
      1:       coin_1 = lvl;
      2:       coin_2 = lvl;
      default: coin_5 = lvl;
    endcase
  endtask

  function automatic int price_of(input int x);
    return (x == 1) ? PR1 : PR2;
  endfunction

  // Insert one coin; the result is visible 2 + DEB edges after the raw edge.
  task automatic insert_coin(input int v);
    logic exp_rej;
    exp_rej = (model_credit + v > MAXC);
    if (!exp_rej) model_credit += v;
    set_coin(v, 1'b1);
    tick(2 + DEB);
    check("coin_reject", coin_reject, exp_rej);
    check("coin_credit", credit, model_credit);
    tick(1);
    check("reject_one_cycle", coin_reject, 1'b0);
    set_coin(v, 1'b0);
    tick(4);
  endtask

  task automatic finish_change(input int dly);
    check("change_valid", change_valid, 1'b1);
    check("change_amt", change_amt, model_credit);
    for (int i = 0; i < dly; i++) begin
      tick(1);
      check("change_hold_valid", change_valid, 1'b1);
      check("change_hold_amt", change_amt, model_credit);
    end
    change_ready = 1'b1;
    tick(1);
    change_ready = 1'b0;
    model_credit = 0;
    check("change_done_valid", change_valid, 1'b0);
    check("change_done_credit", credit, 0);
    check("change_done_state", fsm_state, IDLE);
  endtask

  task automatic press_sel(input int x, input int ready_dly, input int change_dly);
    int price;
    price = price_of(x);
    if (x == 1) sel_1 = 1'b1; else sel_2 = 1'b1;
    tick(1);
    sel_1 = 1'b0;
    sel_2 = 1'b0;
    if (model_credit >= price) begin
      check("vend_valid", vend_valid, 1'b1);
      check("vend_item", vend_item, x);
      for (int i = 0; i < ready_dly; i++) begin
        tick(1);
        check("vend_hold_valid", vend_valid, 1'b1);
        check("vend_hold_item", vend_item, x);
      end
      vend_ready = 1'b1;
      tick(1);
      vend_ready = 1'b0;
      model_credit -= price;
      check("vend_done_valid", vend_valid, 1'b0);
      check("vend_done_item", vend_item, 0);
      check("vend_done_credit", credit, model_credit);
      if (model_credit > 0) begin
        finish_change(change_dly);
      end else begin
        check("no_change_valid", change_valid, 1'b0);
        check("vend_idle_state", fsm_state, IDLE);
      end
    end else begin
      check("sel_ignored_valid", vend_valid, 1'b0);
      check("sel_ignored_credit", credit, model_credit);
    end
  endtask

  task automatic press_cancel(input int dly);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    if (model_credit > 0) begin
      finish_change(dly);
    end else begin
      check("cancel_idle_change", change_valid, 1'b0);
      check("cancel_idle_state", fsm_state, IDLE);
    end
  endtask

  // Watchdog: the sequence below is bounded, this only guards against a stall.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit seen;

    // Reset state
    tick(2);
    check("rst_credit", credit, 0);
    check("rst_vend_valid", vend_valid, 1'b0);
    check("rst_change_valid", change_valid, 1'b0);
    check("rst_state", fsm_state, IDLE);
    rst = 1'b0;
    tick(1);

    // 1. Exact coin latency, single credit for a long hold, short pulse ignored
    coin_5 = 1'b1;
    tick(1 + DEB);
    check("lat_before", credit, 0);
    tick(1);
    check("lat_at", credit, 5);
    tick(2);
    coin_5 = 1'b0;
    tick(6);
    check("long_hold_once", credit, 5);
    model_credit = 5;
    coin_5 = 1'b1;
    tick(3);
    coin_5 = 1'b0;
    tick(8);
    check("short_pulse_credit", credit, 5);
    check("short_pulse_state", fsm_state, ACCUM);
    press_cancel(1);

    // Ready with no valid is ignored
    vend_ready = 1'b1;
    change_ready = 1'b1;
    tick(2);
    vend_ready = 1'b0;
    change_ready = 1'b0;
    check("stray_ready_vend", vend_valid, 1'b0);
    check("stray_ready_change", change_valid, 1'b0);

    // 2. 1+2 then juice 1, exact cost, no change
    insert_coin(1);
    insert_coin(2);
    press_sel(1, 3, 0);

    // 3. 5 then juice 1, change of 2
    insert_coin(5);
    press_sel(1, 0, 2);

    // 4. Ceiling and simultaneous coins
    insert_coin(5);
    insert_coin(5);
    insert_coin(5);
    insert_coin(2);
    insert_coin(1);
    check("ceiling_credit", credit, 18);
    insert_coin(5);
    coin_1 = 1'b1;
    coin_2 = 1'b1;
    tick(2 + DEB);
    check("dual_coin_reject", coin_reject, 1'b1);
    check("dual_coin_credit", credit, 18);
    coin_1 = 1'b0;
    coin_2 = 1'b0;
    tick(4);
    // Both buttons pulsed: juice 1 wins
    sel_1 = 1'b1;
    sel_2 = 1'b1;
    tick(1);
    sel_1 = 1'b0;
    sel_2 = 1'b0;
    check("both_sel_item", vend_item, ITEM_1);
    vend_ready = 1'b1;
    tick(1);
    vend_ready = 1'b0;
    model_credit = 15;
    finish_change(0);

    // 5. Insufficient credit, cancel, cancel beats sel, reset mid-VEND
    insert_coin(2);
    press_sel(2, 0, 0);
    press_cancel(0);
    insert_coin(5);
    cancel = 1'b1;
    sel_1 = 1'b1;
    tick(1);
    cancel = 1'b0;
    sel_1 = 1'b0;
    check("cancel_beats_sel", vend_valid, 1'b0);
    finish_change(0);
    insert_coin(5);
    sel_1 = 1'b1;
    tick(1);
    sel_1 = 1'b0;
    check("pre_rst_vend", vend_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_vend_valid", vend_valid, 1'b0);
    check("async_rst_vend_item", vend_item, 0);
    check("async_rst_credit", credit, 0);
    check("async_rst_change", {change_valid, change_amt}, 0);
    check("async_rst_state", fsm_state, IDLE);
    tick(1);
    rst = 1'b0;
    model_credit = 0;
    tick(1);

    // 6. Inactivity
    insert_coin(2);
`ifdef COIN_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 0; i < TO + 50 && !seen; i++) begin
      tick(1);
      seen = change_valid;
    end
    check("timeout_fired", seen, 1'b1);
    finish_change(0);
`else
    tick(TO + 50);
    check("no_timeout_credit", credit, 2);
    check("no_timeout_change", change_valid, 1'b0);
    press_cancel(0);
`endif

    // Randomized transactions against the credit model
    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        case ($urandom_range(0, 2))
          0:       insert_coin(1);
          1:       insert_coin(2);
          default: insert_coin(5);
        endcase
      end else if (op <= 7) begin
        press_sel($urandom_range(1, 2), $urandom_range(0, 3), $urandom_range(0, 3));
      end else if (op == 8) begin
        press_cancel($urandom_range(0, 3));
      end else begin
        tick($urandom_range(1, 5));
        check("rand_idle_credit", credit, model_credit);
      end
    end
    press_cancel(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
